reloj_hms: RTL
==============

# reloj_hms

Parametrised time-of-day counter for the RELOJ clock design: derives a 1 Hz tick from the single system clock and keeps seconds, minutes and hours in BCD, in either 12-hour or 24-hour mode. It supports a validated synchronous time load and produces a blink/seconds indicator and an end-of-day carry. It drives the display multiplexer directly and replaces the earlier minutes/hours-only counter with its separate set clock.

## Interface

Parameters:
- DIV, 50_000_000, system clock cycles per second; must be ≥ 2.
- HOUR_24, 1, 1 = 00–23 hour range; 0 = 12-hour range 12,01–11 with AM/PM flag.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ajuste  input  1  load request, level-sensitive.
- ajuste_dhora  input  2  load value, hour tens (BCD).
- ajuste_uhora  input  4  load value, hour units (BCD).
- ajuste_dmin  input  3  load value, minute tens (BCD).
- ajuste_umin  input  4  load value, minute units (BCD).
- ajuste_pm  input  1  load value, PM flag; ignored when HOUR_24=1.
- ajuste_err  output  1  one-cycle pulse: load request rejected.
- Useg / Dseg  output  4 / 3  seconds units / tens (BCD).
- Umin / Dmin  output  4 / 3  minutes units / tens (BCD).
- Uhora / Dhora  output  4 / 2  hours units / tens (BCD).
- pm  output  1  PM flag; constant 0 when HOUR_24=1.
- segundo  output  1  1 Hz square wave; high for the first half of each second.
- fin_dia  output  1  one-cycle pulse on wrap to the start of day.

## Operation

- **Prescaler.**
  - Counts 0..DIV-1, then wraps.
  - Tick = prescaler at DIV-1.
  - segundo = 1 while prescaler < DIV/2 (integer division).
- **Tick advance.** On each tick, if ajuste=0, advance time by one second:
  - Useg 9→0 carries into Dseg.
  - Dseg 5→0 carries into minutes.
  - Minutes use the same rule: units 0–9, tens 0–5.
  - Minute 59→00 advances the hour.
- **24-hour mode.** 23:59:59 → 00:00:00; fin_dia pulses on that edge.
- **12-hour mode.**
  - Hours run 12→01→…→11→12.
  - 11:59:59 → 12:00:00 toggles pm.
  - fin_dia pulses only on the PM→AM transition (11:59:59 PM → 12:00:00 AM).
- **Load.** While ajuste=1, on every clock edge the inputs are validated:
  - Minutes must be ≤ 59 with units ≤ 9.
  - Hours must be ≤ 23 (24h mode) or 01..12 (12h mode).
  - Valid: hours, minutes and pm load; seconds clear to 00; prescaler clears to 0.
  - Invalid: time registers hold; ajuste_err pulses for one cycle per invalid edge.
  - Ticks are suppressed while ajuste=1 and fin_dia never asserts.
- **Release.** After ajuste falls, the first tick occurs DIV cycles after the last load edge, so a full second elapses before 00→01.
- **Reset values.**
  - 24h: 00:00:00, pm=0.
  - 12h: 12:00:00, pm=0.
  - Prescaler=0; segundo=1 (prescaler 0 < DIV/2).
  - ajuste_err=0, fin_dia=0.
- **Reset mid-operation.** Reset overrides any tick, load or pulse in progress immediately.

## Timing

- Time outputs update on the rising edge where prescaler = DIV-1: 1 cycle after the tick condition is present, with no further latency.
- A load takes effect on the first rising edge with ajuste=1 and is visible in the same cycle.
- fin_dia and ajuste_err are registered single-cycle pulses, coincident with the edge that updates the time or rejects the load.
- When ajuste=1 and a tick coincide, the load wins and the tick is discarded.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- **Macro:** RELOJ_ALARM_EN.
- **When defined**, the module adds:
  - inputs alarma_dhora[1:0], alarma_uhora[3:0], alarma_dmin[2:0], alarma_umin[3:0], alarma_pm, alarma_on;
  - output alarma.
- **Alarm assertion.** alarma sets on the tick edge where the new time equals the alarm hour/minute (and pm in 12h mode) with seconds = 00, provided alarma_on=1.
- **Alarm clear.** alarma clears when either:
  - alarma_on goes to 0 (next edge), or
  - 60 ticks have elapsed after assertion.
- **Alarm reset value:** alarma = 0.
- **When not defined**, the alarm ports and logic are absent and the rest of the behaviour is identical.

## Test plan

- **Reset/prescaler:** DIV=4, HOUR_24=1, reset pulse.
  - Outputs read 00:00:00.
  - segundo follows the pattern 1,1,0,0.
  - Useg=1 after 4 clocks.
- **24h rollover:** load 23:59, release, run 59 ticks.
  - Reads 23:59:59.
  - Next tick gives 00:00:00 with fin_dia high for exactly 1 cycle.
- **12h mode:** HOUR_24=0.
  - Load 11:59 PM, run 60 ticks → 12:00:00 AM, pm=0, fin_dia pulse.
  - Load 11:59 AM, run 60 ticks → 12:00:00, pm=1, no fin_dia.
- **Invalid load:**
  - ajuste=1 with minutes 6/0 → ajuste_err pulses every cycle and time is unchanged.
  - HOUR_24=0 with hour 00 → rejected.
  - HOUR_24=0 with hour 12 → accepted.
- **Load/tick collision and async reset:**
  - Assert ajuste on the prescaler=DIV-1 edge → loaded value with seconds 00, no increment.
  - Assert reset mid-second → immediate return to reset values.
- **RELOJ_ALARM_EN:**
  - Alarm 07:30 with alarma_on=1; load 07:29 and run 60 ticks → alarma rises at 07:30:00 and falls after 60 ticks.
  - With alarma_on dropped at 07:30:05 → alarma falls on the next edge.

Source files
------------

// File: rtl/reloj_hms.sv
// ============================================================================
// Module   : reloj_hms
// Summary  : BCD time-of-day counter (hh:mm:ss) with 1 Hz prescaler,
//            12/24-hour modes and validated synchronous time load.
//            Optional alarm enabled by defining RELOJ_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reloj_hms #(
  parameter int DIV     = 50_000_000,
  parameter int HOUR_24 = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ajuste,
  input  logic [1:0] ajuste_dhora,
  input  logic [3:0] ajuste_uhora,
  input  logic [2:0] ajuste_dmin,
  input  logic [3:0] ajuste_umin,
  input  logic       ajuste_pm,
`ifdef RELOJ_ALARM_EN
  input  logic [1:0] alarma_dhora,
  input  logic [3:0] alarma_uhora,
  input  logic [2:0] alarma_dmin,
  input  logic [3:0] alarma_umin,
  input  logic       alarma_pm,
  input  logic       alarma_on,
  output logic       alarma,
`endif
  output logic       ajuste_err,
  output logic [3:0] Useg,
  output logic [2:0] Dseg,
  output logic [3:0] Umin,
  output logic [2:0] Dmin,
  output logic [3:0] Uhora,
  output logic [1:0] Dhora,
  output logic       pm,
  output logic       segundo,
  output logic       fin_dia
);

  localparam int               c_PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [c_PW-1:0]  c_LAST = c_PW'(DIV - 1);
  localparam logic [c_PW-1:0]  c_HALF = c_PW'(DIV / 2);
  localparam logic [1:0]       c_RST_DH = (HOUR_24 != 0) ? 2'd0 : 2'd1;
  localparam logic [3:0]       c_RST_UH = (HOUR_24 != 0) ? 4'd0 : 4'd2;

  logic [c_PW-1:0] r_pre;
  logic            r_seg;
  logic [3:0]      r_us;
  logic [2:0]      r_ds;
  logic [3:0]      r_um;
  logic [2:0]      r_dm;
  logic [3:0]      r_uh;
  logic [1:0]      r_dh;
  logic            r_pm;
  logic            r_err;
  logic            r_fin;

  logic            w_tick;
  logic [c_PW-1:0] w_pre_nxt;
  logic            w_seg_nxt;
  logic [3:0]      w_us;
  logic [2:0]      w_ds;
  logic [3:0]      w_um;
  logic [2:0]      w_dm;
  logic [3:0]      w_uh;
  logic [1:0]      w_dh;
  logic            w_pm;
  logic            w_wrap;
  logic            w_ok;

  assign w_tick    = (r_pre == c_LAST);
  assign w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
  assign w_seg_nxt = (w_pre_nxt < c_HALF);

  // Time one second ahead of the current registers.
  always_comb begin
    w_us   = r_us;
    w_ds   = r_ds;
    w_um   = r_um;
    w_dm   = r_dm;
    w_uh   = r_uh;
    w_dh   = r_dh;
    w_pm   = r_pm;
    w_wrap = 1'b0;
    if (r_us != 4'd9) begin
      w_us = r_us + 4'd1;
    end else begin
      w_us = 4'd0;
      if (r_ds != 3'd5) begin
        w_ds = r_ds + 3'd1;
      end else begin
        w_ds = 3'd0;
        if (r_um != 4'd9) begin
          w_um = r_um + 4'd1;
        end else begin
          w_um = 4'd0;
          if (r_dm != 3'd5) begin
            w_dm = r_dm + 3'd1;
          end else begin
            w_dm = 3'd0;
            if (HOUR_24 != 0) begin
              if (r_dh == 2'd2 && r_uh == 4'd3) begin
                w_dh   = 2'd0;
                w_uh   = 4'd0;
                w_wrap = 1'b1;
              end else if (r_uh == 4'd9) begin
                w_dh = r_dh + 2'd1;
                w_uh = 4'd0;
              end else begin
                w_uh = r_uh + 4'd1;
              end
            end else begin
              // 12 is followed by 01; 11 -> 12 flips the meridian.
              if (r_dh == 2'd1 && r_uh == 4'd2) begin
                w_dh = 2'd0;
                w_uh = 4'd1;
              end else if (r_dh == 2'd1 && r_uh == 4'd1) begin
                w_uh   = 4'd2;
                w_pm   = ~r_pm;
                w_wrap = r_pm;
              end else if (r_uh == 4'd9) begin
                w_dh = 2'd1;
                w_uh = 4'd0;
              end else begin
                w_uh = r_uh + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_ok = (ajuste_dmin <= 3'd5) && (ajuste_umin <= 4'd9);
    if (HOUR_24 != 0) begin
      w_ok = w_ok && (ajuste_uhora <= 4'd9) &&
             ((ajuste_dhora < 2'd2) || (ajuste_dhora == 2'd2 && ajuste_uhora <= 4'd3));
    end else begin
      w_ok = w_ok &&
             ((ajuste_dhora == 2'd0 && ajuste_uhora != 4'd0 && ajuste_uhora <= 4'd9) ||
              (ajuste_dhora == 2'd1 && ajuste_uhora <= 4'd2));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_seg <= 1'b1;
      r_us  <= 4'd0;
      r_ds  <= 3'd0;
      r_um  <= 4'd0;
      r_dm  <= 3'd0;
      r_uh  <= c_RST_UH;
      r_dh  <= c_RST_DH;
      r_pm  <= 1'b0;
      r_err <= 1'b0;
      r_fin <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_fin <= 1'b0;
      if (ajuste) begin
        if (w_ok) begin
          // Restart the second so a full DIV cycles elapse after release.
          r_pre <= '0;
          r_seg <= 1'b1;
          r_us  <= 4'd0;
          r_ds  <= 3'd0;
          r_um  <= ajuste_umin;
          r_dm  <= ajuste_dmin;
          r_uh  <= ajuste_uhora;
          r_dh  <= ajuste_dhora;
          r_pm  <= (HOUR_24 != 0) ? 1'b0 : ajuste_pm;
        end else begin
          r_pre <= w_pre_nxt;
          r_seg <= w_seg_nxt;
          r_err <= 1'b1;
        end
      end else begin
        r_pre <= w_pre_nxt;
        r_seg <= w_seg_nxt;
        if (w_tick) begin
          r_us  <= w_us;
          r_ds  <= w_ds;
          r_um  <= w_um;
          r_dm  <= w_dm;
          r_uh  <= w_uh;
          r_dh  <= w_dh;
          r_pm  <= w_pm;
          r_fin <= w_wrap;
        end
      end
    end
  end

`ifdef RELOJ_ALARM_EN
  logic       r_alarma;
  logic [5:0] r_al_cnt;
  logic       w_tick_en;
  logic       w_al_hit;

  assign w_tick_en = w_tick && !ajuste;
  assign w_al_hit  = w_tick_en && (w_us == 4'd0) && (w_ds == 3'd0) &&
                     (w_um == alarma_umin) && (w_dm == alarma_dmin) &&
                     (w_uh == alarma_uhora) && (w_dh == alarma_dhora) &&
                     ((HOUR_24 != 0) || (w_pm == alarma_pm));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alarma <= 1'b0;
      r_al_cnt <= 6'd0;
    end else if (!alarma_on) begin
      r_alarma <= 1'b0;
      r_al_cnt <= 6'd0;
    end else if (w_al_hit) begin
      r_alarma <= 1'b1;
      r_al_cnt <= 6'd0;
    end else if (r_alarma && w_tick_en) begin
      if (r_al_cnt == 6'd59) begin
        r_alarma <= 1'b0;
        r_al_cnt <= 6'd0;
      end else begin
        r_al_cnt <= r_al_cnt + 6'd1;
      end
    end
  end

  assign alarma = r_alarma;
`endif

  assign ajuste_err = r_err;
  assign Useg       = r_us;
  assign Dseg       = r_ds;
  assign Umin       = r_um;
  assign Dmin       = r_dm;
  assign Uhora      = r_uh;
  assign Dhora      = r_dh;
  assign pm         = r_pm;
  assign segundo    = r_seg;
  assign fin_dia    = r_fin;

endmodule

`default_nettype wire
